// File: rtl/icache_loader_pkg.sv
// Shared types and constants for the instruction-cache loader.
// The optional trailing checksum byte is enabled by defining ICACHE_LOADER_CHECKSUM_EN.
package icache_loader_pkg;

    localparam int unsigned DepthDefault = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDataLo,
        StDataHi,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/icache_loader.sv
// Loads a length-prefixed little-endian byte stream into an instruction store, holding the CPU off.
// Define ICACHE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module icache_loader
    import icache_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        write_enable,
    output logic [31:0] write_instruction_index,
    output logic [15:0] write_instruction,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  lo_q, lo_d;
    logic [31:0] idx_q, idx_d;
    logic [15:0] instr_q, instr_d;
    logic        we_q, we_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef ICACHE_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        xfer;
    logic        last_slot;
    logic [15:0] len_word;
    logic        len_bad;

    // The strobe cycle reuses StDataHi with we_q high, so ready must drop then.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StLenLo, StLenHi, StDataLo, StDataHi, StCheck: in_ready = !we_q;
            default: in_ready = 1'b0;
        endcase
    end

    assign xfer      = in_valid && in_ready;
    assign last_slot = (idx_q == ({16'd0, count_q} - 32'd1));
    assign len_word  = {in_data, lo_q};
    assign len_bad   = (len_word == 16'd0) || ({16'd0, len_word} > DEPTH);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        instr_d = instr_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLenLo;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    idx_d   = 32'd0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            StLenLo: begin
                if (xfer) begin
                    lo_d    = in_data;
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    count_d = len_word;
                    if (len_bad) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StDataLo;
                    end
                end
            end
            StDataLo: begin
                if (xfer) begin
                    lo_d    = in_data;
`ifdef ICACHE_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = StDataHi;
                end
            end
            StDataHi: begin
                if (we_q) begin
                    if (last_slot) begin
`ifdef ICACHE_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        idx_d   = idx_q + 32'd1;
                        state_d = StDataLo;
                    end
                end else if (xfer) begin
                    instr_d = {in_data, lo_q};
                    we_d    = 1'b1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                end
            end
`ifdef ICACHE_LOADER_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    err_d   = (in_data != csum_q);
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= 16'd0;
            lo_q    <= 8'd0;
            idx_q   <= 32'd0;
            instr_q <= 16'd0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lo_q    <= lo_d;
            idx_q   <= idx_d;
            instr_q <= instr_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef ICACHE_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign write_enable            = we_q;
    assign write_instruction_index = idx_q;
    assign write_instruction       = instr_q;
    assign cpu_hold                = hold_q;
    assign done                    = done_q;
    assign error                   = err_q;

endmodule

// File: tb/tb_icache_loader.sv
// Self-checking bench for icache_loader: directed table, reset abort, N=DEPTH boundary, random loads.
// Honours ICACHE_LOADER_CHECKSUM_EN by appending/expecting the checksum byte.
module tb_icache_loader;

    localparam int unsigned DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        write_enable;
    logic [31:0] write_instruction_index;
    logic [15:0] write_instruction;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    icache_loader #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .in_valid                (in_valid),
        .in_data                 (in_data),
        .in_ready                (in_ready),
        .write_enable            (write_enable),
        .write_instruction_index (write_instruction_index),
        .write_instruction       (write_instruction),
        .cpu_hold                (cpu_hold),
        .done                    (done),
        .error                   (error)
    );

    typedef logic [7:0] bq_t[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] wlog[$];      // {index, data} of every observed strobe
    logic [15:0] exp_w[$];
    bit          exp_e;
    logic [31:0] exp_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wlog.push_back({write_instruction_index, write_instruction});
            check("ready_low_during_strobe", {31'd0, in_ready}, 32'd0);
        end
    end

    // Reference: what the store should receive, straight from the stream layout.
    function automatic void model(input bq_t s);
        int   n;
        logic [7:0] x;
        n = int'({s[1], s[0]});
        exp_w.delete();
        exp_e    = 1'b0;
        exp_last = 32'd0;
        if (n == 0 || n > int'(DEPTH)) begin
            exp_e = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) exp_w.push_back({s[3 + 2 * i], s[2 + 2 * i]});
        exp_last = 32'(n - 1);
        x = 8'd0;
        for (int j = 2; j < 2 + 2 * n; j++) x = x ^ s[j];
`ifdef ICACHE_LOADER_CHECKSUM_EN
        exp_e = (s[2 + 2 * n] != x);
`endif
    endfunction

    task automatic send_bytes(input bq_t s, input bit gaps, input bit inject, output bit ok);
        bit acc;
        int guard;
        ok = 1'b1;
        foreach (s[i]) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                start = inject && ($urandom_range(0, 5) == 0);
                if (gaps && $urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = s[i];
                    acc      = in_ready;
                end
                @(negedge clk);
                guard++;
                if (!acc && guard > 200) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL byte_timeout: byte %0d never accepted", i);
                    ok       = 1'b0;
                    start    = 1'b0;
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Called at a negedge; pulses start, streams bytes, waits for done.
    task automatic run_load(input bq_t s, input bit gaps, input bit inject);
        bit ok;
        int guard;
        wlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("done_clear_after_start", {31'd0, done}, 32'd0);
        check("error_clear_after_start", {31'd0, error}, 32'd0);
        send_bytes(s, gaps, inject, ok);
        guard = 0;
        while (done !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (ok) check("done_reached", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic compare_result(input string name);
        check({name, "_nwrites"}, 32'(wlog.size()), 32'(exp_w.size()));
        foreach (exp_w[i]) begin
            if (i < wlog.size()) begin
                check({name, "_idx"}, wlog[i][47:16], 32'(i));
                check({name, "_data"}, {16'd0, wlog[i][15:0]}, {16'd0, exp_w[i]});
            end
        end
        check({name, "_error"}, {31'd0, error}, {31'd0, exp_e});
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({name, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_final_idx"}, write_instruction_index, exp_last);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_we"}, {31'd0, write_enable}, 32'd0);
        check({name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_error"}, {31'd0, error}, 32'd0);
        check({name, "_idx"}, write_instruction_index, 32'd0);
        check({name, "_instr"}, {16'd0, write_instruction}, 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] b [0:7];
        int         len;
        int         nw;
        logic [15:0] w0;
        logic [15:0] w1;
        bit         err;
        logic [31:0] last;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        bq_t  s;
        bit   ok;
        int   n;

        // Directed table; the checksum byte 0x26 is 0x34 ^ 0x12.
        v.name = "two_words";   v.b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00};
        v.nw = 2; v.w0 = 16'h1234; v.w1 = 16'h5678; v.err = 1'b0; v.last = 32'd1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        v.b[6] = 8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56; v.len = 7;
`else
        v.len = 6;
`endif
        vecs.push_back(v);
        v.name = "len_zero";    v.b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v.len = 2; v.nw = 0; v.w0 = 16'h0; v.w1 = 16'h0; v.err = 1'b1; v.last = 32'd0;
        vecs.push_back(v);
        v.name = "len_over";    v.b = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v.len = 2; v.nw = 0; v.err = 1'b1; v.last = 32'd0;
        vecs.push_back(v);
        v.name = "one_word";    v.b = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h26, 8'h00, 8'h00, 8'h00};
        v.nw = 1; v.w0 = 16'h1234; v.err = 1'b0; v.last = 32'd0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        v.len = 5;
        vecs.push_back(v);
        v.name = "bad_csum"; v.b[4] = 8'h27; v.err = 1'b1;
        vecs.push_back(v);
`else
        v.len = 4;
        vecs.push_back(v);
`endif

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        foreach (vecs[k]) begin
            s.delete();
            for (int j = 0; j < vecs[k].len; j++) s.push_back(vecs[k].b[j]);
            run_load(s, 1'b0, 1'b0);
            check({vecs[k].name, "_nwrites"}, 32'(wlog.size()), 32'(vecs[k].nw));
            if (vecs[k].nw > 0 && wlog.size() > 0)
                check({vecs[k].name, "_w0"}, {wlog[0][47:16] , 16'h0} | 32'(wlog[0][15:0]),
                      32'(vecs[k].w0));
            if (vecs[k].nw > 1 && wlog.size() > 1) begin
                check({vecs[k].name, "_w1"}, {16'd0, wlog[1][15:0]}, {16'd0, vecs[k].w1});
                check({vecs[k].name, "_w1_idx"}, wlog[1][47:16], 32'd1);
            end
            check({vecs[k].name, "_error"}, {31'd0, error}, {31'd0, vecs[k].err});
            check({vecs[k].name, "_done"}, {31'd0, done}, 32'd1);
            check({vecs[k].name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
            check({vecs[k].name, "_final_idx"}, write_instruction_index, vecs[k].last);
        end

        // Reset lands on the same edge as the DATA_HI byte: no strobe may follow.
        wlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = '{8'h01, 8'h00, 8'h34};
        send_bytes(s, 1'b0, 1'b0, ok);
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h12;
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        check("abort_no_strobe", 32'(wlog.size()), 32'd0);
        s = '{8'h01, 8'h00, 8'hcd, 8'hab};
`ifdef ICACHE_LOADER_CHECKSUM_EN
        s.push_back(8'hcd ^ 8'hab);
`endif
        model(s);
        run_load(s, 1'b0, 1'b0);
        compare_result("reload");

        // Boundary: exactly DEPTH instructions.
        s = '{8'(DEPTH), 8'(DEPTH >> 8)};
        for (int i = 0; i < 2 * int'(DEPTH); i++) s.push_back(8'(i * 7 + 3));
`ifdef ICACHE_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        model(s);
        run_load(s, 1'b1, 1'b0);
        compare_result("full_depth");

        // Random loads with gaps and stray start pulses.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = int'(DEPTH) + 1 + int'($urandom_range(0, 300));
                default: n = int'($urandom_range(1, 8));
            endcase
            s = '{8'(n), 8'(n >> 8)};
            if (n >= 1 && n <= int'(DEPTH)) begin
                for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
`ifdef ICACHE_LOADER_CHECKSUM_EN
                s.push_back(8'($urandom_range(0, 1)));
                begin
                    logic [7:0] x;
                    x = 8'd0;
                    for (int j = 2; j < 2 + 2 * n; j++) x = x ^ s[j];
                    if ($urandom_range(0, 2) != 0) s[2 + 2 * n] = x;
                end
`endif
            end
            model(s);
            run_load(s, 1'b1, 1'b1);
            compare_result("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_loader.md
ICACHE_LOADER -- requirements
Module: icache_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning the number of instruction slots in the target instruction store.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load; ignored unless the FSM is in IDLE or DONE.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_data  input  8  byte-stream payload.
REQ-007 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready on posedge.
REQ-008 SHALL have port write_enable  output  1  instruction-store write strobe.
REQ-009 SHALL have port write_instruction_index  output  32  instruction-store write slot.
REQ-010 SHALL have port write_instruction  output  16  instruction-store write data.
REQ-011 SHALL have port cpu_hold  output  1  drives the instruction store's not_enable; holds the CPU off during a load.
REQ-012 SHALL have port done  output  1  load finished, sticky until next accepted start.
REQ-013 SHALL have port error  output  1  load failed, sticky until next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE.
REQ-015 SHALL on accepted start: clear done and error, set cpu_hold, zero the index, go to LEN_LO.
REQ-016 SHALL assert in_ready only in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, and never in the cycle write_enable is high.
REQ-017 SHALL read a 16-bit little-endian instruction count N (LEN_LO then LEN_HI).
REQ-018 SHALL, if N == 0 or N > DEPTH, set error and done, clear cpu_hold, enter DONE without any write.
REQ-019 SHALL assemble each instruction little-endian: DATA_LO byte = bits [7:0], DATA_HI byte = bits [15:8].
REQ-020 SHALL assert write_enable for exactly one cycle, the cycle after the DATA_HI byte transfers, with write_instruction and write_instruction_index stable for that cycle.
REQ-021 SHALL write slots 0 to N-1 in order, index incrementing by 1 after each strobe; no wrap past N-1.
REQ-022 SHALL, after the strobe for slot N-1, proceed to CHECK (macro defined) or DONE (macro undefined).
REQ-023 SHALL on entering DONE set done, clear cpu_hold, keep index at its last value.
REQ-024 SHALL stall indefinitely in any byte state while in_valid is low; no timeout.
REQ-025 SHALL ignore start asserted in any state other than IDLE/DONE.
REQ-026 SHALL drive write_enable low in every cycle not specified in REQ-020.

Reset
REQ-027 SHALL on rst, regardless of state, go to IDLE and drive in_ready, write_enable, cpu_hold, done, error = 0, write_instruction_index = 0, write_instruction = 0.
REQ-028 SHALL give rst priority over start and over a simultaneous byte transfer; a load interrupted mid-stream is abandoned, with no partial strobe.

Configuration
REQ-029 SHALL, with ICACHE_LOADER_CHECKSUM_EN defined, accept one extra byte in CHECK, compare it to the XOR of all 2N data bytes (header excluded), set error on mismatch, then enter DONE.
REQ-030 SHALL, without ICACHE_LOADER_CHECKSUM_EN, omit CHECK and the XOR accumulator entirely; error then arises only from REQ-018.

Structure
REQ-031 SHALL place the state enum and DEPTH default constant in package icache_loader_pkg.
REQ-032 SHALL be a single module with no sub-module; the byte assembler is an internal register.

Verification
REQ-033 Bench: start, stream 02 00 34 12 78 56 -> strobes (index 0, 0x1234) then (index 1, 0x5678), one cycle each; done=1, error=0, cpu_hold falls.
REQ-034 Bench: stream 00 00 -> error=1, done=1, no write_enable pulse.
REQ-035 Bench: stream 81 00 with DEPTH=128 -> error=1, done=1, no write.
REQ-036 Bench: macro defined, stream 01 00 34 12 26 -> done=1, error=0; repeat with checksum 27 -> error=1.
REQ-037 Bench: rst asserted between DATA_LO and DATA_HI bytes -> no strobe, all outputs 0; a new start then loads correctly from index 0.
REQ-038 Bench: in_valid toggled randomly and start pulsed mid-load -> identical writes to the ungapped case; the start is ignored.
